// File: rtl/mfp_uart_receiver_param.sv
// UART receiver with configurable frame format, 3-sample majority voting and a small receive FIFO.
// Reports parity, framing, break and overrun conditions alongside each buffered character.
module mfp_uart_receiver_param #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned PARITY          = 0,
  parameter int unsigned STOP_BITS       = 1,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 overrun,
  output logic                 break_detect
);

  localparam int unsigned CYCLES = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned HALF   = CYCLES / 2;
  localparam int unsigned CW     = $clog2(CYCLES);
  localparam int unsigned BW     = $clog2(DATA_BITS);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned FW     = DATA_BITS + 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2,
    StWaitHigh
  } state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   samp0_q, samp1_q;
  logic                   par_bit_q, par_bit_d;
  logic                   par_err_q, par_err_d;
  logic                   stop1_q, stop1_d;
  logic                   decide, bit_val, start_edge, exp_par;
  logic                   push, brk, frame_fe, all_zero, stop1_eff;
  logic [FW-1:0]          push_word;

  logic [FW-1:0]          mem_q [FIFO_DEPTH];
  logic [AW:0]            wr_ptr_q, rd_ptr_q;
  logic                   full, empty, pop, do_push;
  logic                   overrun_q, break_q;

  assign start_edge = rx_prev_q & ~rx_sync_q;
  assign decide     = (state_q != StIdle) && (state_q != StWaitHigh) && (cnt_q == CW'(HALF + 1));
  assign bit_val    = (samp0_q & samp1_q) | (samp0_q & rx_sync_q) | (samp1_q & rx_sync_q);
  assign exp_par    = (PARITY == 1) ? ~(^shift_q) : (^shift_q);

  // Synchroniser, edge history and mid-bit samples
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      samp0_q   <= 1'b1;
      samp1_q   <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      if (cnt_q == CW'(HALF - 1)) samp0_q <= rx_sync_q;
      if (cnt_q == CW'(HALF)) samp1_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
      stop1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      par_err_q <= par_err_d;
      stop1_q   <= stop1_d;
    end
  end

  // With one stop bit the current decision is both the first and final stop bit
  assign stop1_eff = (STOP_BITS == 2) ? stop1_q : bit_val;
  assign all_zero  = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !stop1_eff && !bit_val;
  assign frame_fe  = !stop1_eff || !bit_val;
  assign push_word = {shift_q, par_err_q, frame_fe};

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CW'(CYCLES - 1)) ? '0 : cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    par_err_d = par_err_q;
    stop1_d   = stop1_q;
    push      = 1'b0;
    brk       = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start_edge) begin
          state_d   = StStart;
          cnt_d     = CW'(1);
          bit_idx_d = '0;
          par_bit_d = 1'b0;
          par_err_d = 1'b0;
        end
      end
      StStart: begin
        if (decide) state_d = bit_val ? StIdle : StData;
      end
      StData: begin
        if (decide) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == BW'(DATA_BITS - 1)) begin
            state_d = (PARITY != 0) ? StParity : StStop1;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end
      StParity: begin
        if (decide) begin
          par_bit_d = bit_val;
          par_err_d = (bit_val != exp_par);
          state_d   = StStop1;
        end
      end
      StStop1, StStop2: begin
        if (decide) begin
          stop1_d = (state_q == StStop1) ? bit_val : stop1_q;
          if ((state_q == StStop1) && (STOP_BITS == 2)) begin
            state_d = StStop2;
          end else if (all_zero) begin
            brk     = 1'b1;
            state_d = StWaitHigh;
          end else begin
            push    = 1'b1;
            state_d = bit_val ? StIdle : StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        cnt_d = '0;
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO: pointers carry an extra wrap bit to distinguish full from empty
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && data_ready;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_word;
        wr_ptr_q                <= wr_ptr_q + (AW + 1)'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
      overrun_q <= push && full && !pop;
      break_q   <= brk;
    end
  end

  assign {data, parity_error, framing_error} = mem_q[rd_ptr_q[AW-1:0]];
  assign data_valid   = !empty;
  assign overrun      = overrun_q;
  assign break_detect = break_q;

endmodule

// File: tb/tb_mfp_uart_receiver_param.sv
// Directed bench: three receiver configurations (8N1, 8E1, 7O2) driven with hand-built frames.
module tb_mfp_uart_receiver_param;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic pe_a, fe_a, dv_a, ovr_a, brk_a;
  logic pe_b, fe_b, dv_b, ovr_b, brk_b;
  logic pe_c, fe_c, dv_c, ovr_c, brk_c;

  int tests = 0;
  int failed = 0;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  logic [8:0] q_c[$];
  int ovr_cnt_a = 0, brk_cnt_a = 0, brk_cnt_c = 0;

  always #5 clock = ~clock;

  mfp_uart_receiver_param #(
    .CLOCK_FREQUENCY(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_8n1 (
    .clock(clock), .reset_n(reset_n), .rx(rx_a), .data(data_a), .parity_error(pe_a),
    .framing_error(fe_a), .data_valid(dv_a), .data_ready(ready_a), .overrun(ovr_a),
    .break_detect(brk_a)
  );

  mfp_uart_receiver_param #(
    .CLOCK_FREQUENCY(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_8e1 (
    .clock(clock), .reset_n(reset_n), .rx(rx_b), .data(data_b), .parity_error(pe_b),
    .framing_error(fe_b), .data_valid(dv_b), .data_ready(ready_b), .overrun(ovr_b),
    .break_detect(brk_b)
  );

  mfp_uart_receiver_param #(
    .CLOCK_FREQUENCY(1600000), .BAUD_RATE(100000), .DATA_BITS(7),
    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_7o2 (
    .clock(clock), .reset_n(reset_n), .rx(rx_c), .data(data_c), .parity_error(pe_c),
    .framing_error(fe_c), .data_valid(dv_c), .data_ready(ready_c), .overrun(ovr_c),
    .break_detect(brk_c)
  );

  // Record every accepted entry and every pulse, sampled away from the active edge
  always @(negedge clock) begin
    if (dv_a && ready_a) q_a.push_back({data_a, pe_a, fe_a});
    if (dv_b && ready_b) q_b.push_back({data_b, pe_b, fe_b});
    if (dv_c && ready_c) q_c.push_back({data_c, pe_c, fe_c});
    if (ovr_a) ovr_cnt_a++;
    if (brk_a) brk_cnt_a++;
    if (brk_c) brk_cnt_c++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // 16 cycles per bit, LSB first; optional one-cycle inversion mid-bit
  task automatic send_bits(input int inst, input logic [15:0] bits, input int n,
                           input int glitch_bit);
    logic v;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 16; c++) begin
        v = bits[b];
        if (b == glitch_bit && c == 8) v = ~v;
        set_rx(inst, v);
        @(posedge clock);
        #1;
      end
    end
    set_rx(inst, 1'b1);
  endtask

  task automatic send_8n1(input logic [7:0] d, input int glitch_bit);
    send_bits(0, {6'h00, 1'b1, d, 1'b0}, 10, glitch_bit);
  endtask

  task automatic test_reset;
    tests++;
    if (dv_a !== 1'b0 || dv_b !== 1'b0 || dv_c !== 1'b0) begin
      failed++;
      $display("FAIL reset_valid got %b%b%b want 000", dv_a, dv_b, dv_c);
    end
    tests++;
    if ({data_a, pe_a, fe_a} !== 10'h000) begin
      failed++;
      $display("FAIL reset_head got %h want 000", {data_a, pe_a, fe_a});
    end
    tests++;
    if ({ovr_a, brk_a, brk_c} !== 3'b000) begin
      failed++;
      $display("FAIL reset_pulses got %b want 000", {ovr_a, brk_a, brk_c});
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] e0, e1;
    ready_a = 1'b1;
    q_a.delete();
    send_8n1(8'h55, -1);
    send_8n1(8'hA3, -1);
    idle(40);
    tests++;
    if (q_a.size() != 2) begin
      failed++;
      $display("FAIL b2b_count got %0d want 2", q_a.size());
    end
    e0 = (q_a.size() > 0) ? q_a[0] : '1;
    e1 = (q_a.size() > 1) ? q_a[1] : '1;
    tests++;
    if (e0 !== {8'h55, 2'b00}) begin
      failed++;
      $display("FAIL b2b_first got %h want %h", e0, {8'h55, 2'b00});
    end
    tests++;
    if (e1 !== {8'hA3, 2'b00}) begin
      failed++;
      $display("FAIL b2b_second got %h want %h", e1, {8'hA3, 2'b00});
    end
  endtask

  task automatic test_parity;
    logic [9:0] e0, e1;
    ready_b = 1'b1;
    q_b.delete();
    send_bits(1, {5'h00, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1);
    idle(32);
    send_bits(1, {5'h00, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1);
    idle(40);
    e0 = (q_b.size() > 0) ? q_b[0] : '1;
    e1 = (q_b.size() > 1) ? q_b[1] : '1;
    tests++;
    if (q_b.size() != 2) begin
      failed++;
      $display("FAIL parity_count got %0d want 2", q_b.size());
    end
    tests++;
    if (e0 !== {8'h07, 2'b10}) begin
      failed++;
      $display("FAIL parity_bad got %h want %h", e0, {8'h07, 2'b10});
    end
    tests++;
    if (e1 !== {8'h07, 2'b00}) begin
      failed++;
      $display("FAIL parity_good got %h want %h", e1, {8'h07, 2'b00});
    end
  endtask

  task automatic test_framing_wait_high;
    logic [8:0] e0, e1;
    ready_c = 1'b1;
    q_c.delete();
    // 0x41 has two ones, so odd parity bit is 1; stop1 = 1, stop2 = 0
    send_bits(2, {5'h00, 1'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 11, -1);
    rx_c = 1'b0;
    idle(48);
    tests++;
    if (q_c.size() != 1 || brk_cnt_c != 0) begin
      failed++;
      $display("FAIL frame_hold got size %0d brk %0d want 1 0", q_c.size(), brk_cnt_c);
    end
    rx_c = 1'b1;
    idle(48);
    // 0x2A has three ones, so odd parity bit is 0
    send_bits(2, {5'h00, 1'b1, 1'b1, 1'b0, 7'h2A, 1'b0}, 11, -1);
    idle(40);
    e0 = (q_c.size() > 0) ? q_c[0] : '1;
    e1 = (q_c.size() > 1) ? q_c[1] : '1;
    tests++;
    if (e0 !== {7'h41, 2'b01}) begin
      failed++;
      $display("FAIL frame_err got %h want %h", e0, {7'h41, 2'b01});
    end
    tests++;
    if (q_c.size() != 2 || e1 !== {7'h2A, 2'b00}) begin
      failed++;
      $display("FAIL frame_next got size %0d %h want 2 %h", q_c.size(), e1, {7'h2A, 2'b00});
    end
  endtask

  task automatic test_false_start_glitch;
    int brk0;
    logic [9:0] e0;
    ready_a = 1'b1;
    q_a.delete();
    brk0 = brk_cnt_a;
    rx_a = 1'b0;
    idle(4);
    rx_a = 1'b1;
    idle(200);
    tests++;
    if (q_a.size() != 0 || brk_cnt_a != brk0 || dv_a !== 1'b0) begin
      failed++;
      $display("FAIL false_start got size %0d brk %0d valid %b want 0 0 0",
               q_a.size(), brk_cnt_a - brk0, dv_a);
    end
    // Glitch inverts data bit 2 (a 1) for one cycle at its centre
    send_8n1(8'hC6, 3);
    idle(40);
    e0 = (q_a.size() > 0) ? q_a[0] : '1;
    tests++;
    if (q_a.size() != 1 || e0 !== {8'hC6, 2'b00}) begin
      failed++;
      $display("FAIL glitch got size %0d %h want 1 %h", q_a.size(), e0, {8'hC6, 2'b00});
    end
  endtask

  task automatic test_overrun;
    int ovr0;
    logic [9:0] e;
    ready_a = 1'b0;
    idle(2);
    q_a.delete();
    ovr0 = ovr_cnt_a;
    for (int i = 0; i < 5; i++) begin
      send_8n1(8'h10 + 8'(i), -1);
      idle(20);
    end
    tests++;
    if (dv_a !== 1'b1) begin
      failed++;
      $display("FAIL ovr_valid got %b want 1", dv_a);
    end
    tests++;
    if (ovr_cnt_a - ovr0 != 1) begin
      failed++;
      $display("FAIL ovr_pulses got %0d want 1", ovr_cnt_a - ovr0);
    end
    for (int i = 0; i < 4; i++) begin
      ready_a = 1'b1;
      @(posedge clock);
      #1;
      ready_a = 1'b0;
      idle(3);
    end
    tests++;
    if (q_a.size() != 4 || dv_a !== 1'b0) begin
      failed++;
      $display("FAIL drain_count got %0d valid %b want 4 0", q_a.size(), dv_a);
    end
    for (int i = 0; i < 4; i++) begin
      e = (q_a.size() > i) ? q_a[i] : '1;
      tests++;
      if (e !== {8'h10 + 8'(i), 2'b00}) begin
        failed++;
        $display("FAIL drain_%0d got %h want %h", i, e, {8'h10 + 8'(i), 2'b00});
      end
    end
    ready_a = 1'b1;
  endtask

  task automatic test_break;
    int brk0;
    logic [9:0] e0;
    ready_a = 1'b1;
    q_a.delete();
    brk0 = brk_cnt_a;
    rx_a = 1'b0;
    idle(12 * 16);
    rx_a = 1'b1;
    idle(48);
    tests++;
    if (brk_cnt_a - brk0 != 1 || q_a.size() != 0) begin
      failed++;
      $display("FAIL break got pulses %0d size %0d want 1 0", brk_cnt_a - brk0, q_a.size());
    end
    send_8n1(8'h5A, -1);
    idle(40);
    e0 = (q_a.size() > 0) ? q_a[0] : '1;
    tests++;
    if (q_a.size() != 1 || e0 !== {8'h5A, 2'b00}) begin
      failed++;
      $display("FAIL after_break got size %0d %h want 1 %h", q_a.size(), e0, {8'h5A, 2'b00});
    end
  endtask

  task automatic test_reset_midframe;
    ready_a = 1'b0;
    send_8n1(8'h33, -1);
    idle(20);
    tests++;
    if (dv_a !== 1'b1 || data_a !== 8'h33) begin
      failed++;
      $display("FAIL pre_reset got valid %b data %h want 1 33", dv_a, data_a);
    end
    rx_a = 1'b0;
    idle(40);
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (dv_a !== 1'b0 || data_a !== 8'h00) begin
      failed++;
      $display("FAIL async_reset got valid %b data %h want 0 00", dv_a, data_a);
    end
    rx_a = 1'b1;
    idle(2);
    reset_n = 1'b1;
    idle(300);
    tests++;
    if (dv_a !== 1'b0) begin
      failed++;
      $display("FAIL post_reset got valid %b want 0", dv_a);
    end
    ready_a = 1'b1;
  endtask

  initial begin
    idle(5);
    reset_n = 1'b1;
    idle(5);
    test_reset;
    test_back_to_back;
    test_parity;
    test_framing_wait_high;
    test_false_start_glitch;
    test_overrun;
    test_break;
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after 50000 cycles");
    $fatal(1);
  end

endmodule
